// File: rtl/xor_key_stream_pkg.sv
// Shared widths, default depths and TX FSM state encodings for the XOR key stream stage.
package xor_key_stream_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned KEY_DEPTH_DEFAULT  = 16;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

  // TX launch FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead read: rd_data shows the head whenever not empty.
module byte_fifo
  import xor_key_stream_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [BYTE_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [BYTE_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= AW'(wr_ptr + AW'(1));
      end
      if (do_rd) begin
        rd_ptr <= AW'(rd_ptr + AW'(1));
      end
      case ({do_wr, do_rd})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xor_key_stream.sv
// Repeating-key XOR stage: stores a multi-byte key, encrypts incoming data bytes,
// queues ciphertext and feeds it to the UART transmitter one byte at a time.
module xor_key_stream
  import xor_key_stream_pkg::*;
#(
  parameter int unsigned KEY_DEPTH  = KEY_DEPTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_valid,
  input  logic [BYTE_W-1:0]             key_byte,
  input  logic                          key_clr,
  input  logic                          data_valid,
  input  logic [BYTE_W-1:0]             data_byte,
  input  logic                          tx_active,
  input  logic                          tx_done,
  output logic                          tx_start,
  output logic [BYTE_W-1:0]             tx_data,
  output logic [$clog2(KEY_DEPTH):0]    key_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          key_ovf,
  output logic                          data_ovf
);

  localparam int unsigned KIW = $clog2(KEY_DEPTH);
  localparam int unsigned KLW = KIW + 1;

  logic [BYTE_W-1:0] key_mem [KEY_DEPTH];
  logic [KIW-1:0]    key_rd_ptr;
  logic [KIW-1:0]    key_wr_idx;
  logic              key_full;
  logic              key_empty;
  logic              ptr_last;
  logic [BYTE_W-1:0] cipher_c;
  logic              data_accept;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [BYTE_W-1:0] fifo_head;

  tx_state_e         state;

  assign key_full    = (key_len == KLW'(KEY_DEPTH));
  assign key_empty   = (key_len == '0);
  assign key_wr_idx  = key_len[KIW-1:0];
  assign ptr_last    = ({1'b0, key_rd_ptr} == KLW'(key_len - KLW'(1)));
  assign data_accept = data_valid && !fifo_full;

  // Ciphertext uses the key as it stood before any same-cycle key update.
  assign cipher_c = key_empty ? data_byte : (data_byte ^ key_mem[key_rd_ptr]);

  // Pop only when the launcher is idle and the transmitter is free.
  assign fifo_rd = (state == ST_IDLE) && !fifo_empty && !tx_active;

  // Key byte storage; a clear with a simultaneous key byte restarts the key at slot 0.
  always_ff @(posedge clk) begin
    if (key_clr) begin
      if (key_valid) begin
        key_mem[0] <= key_byte;
      end
    end else if (key_valid && !key_full) begin
      key_mem[key_wr_idx] <= key_byte;
    end
  end

  // Key length, read pointer and overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_len    <= '0;
      key_rd_ptr <= '0;
      key_ovf    <= 1'b0;
      data_ovf   <= 1'b0;
    end else begin
      if (key_clr) begin
        key_len    <= key_valid ? KLW'(1) : '0;
        key_rd_ptr <= '0;
        key_ovf    <= 1'b0;
      end else begin
        if (key_valid) begin
          if (key_full) begin
            key_ovf <= 1'b1;
          end else begin
            key_len <= KLW'(key_len + KLW'(1));
          end
        end
        if (data_accept && !key_empty) begin
          key_rd_ptr <= ptr_last ? '0 : KIW'(key_rd_ptr + KIW'(1));
        end
      end
      if (data_valid && fifo_full) begin
        data_ovf <= 1'b1;
      end
    end
  end

  // Ciphertext queue between the encryptor and the transmitter.
  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_valid),
    .wr_data (cipher_c),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // TX launcher: pop head into tx_data, pulse tx_start, wait for tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_rd) begin
            tx_data  <= fifo_head;
            tx_start <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_key_stream.sv
// Directed testbench for xor_key_stream with a simple transmitter model.
module tb_xor_key_stream;

  localparam int KD = 16;
  localparam int FD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_byte = 8'h00;
  logic       key_clr = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_byte = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_hold = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] key_len;
  logic [3:0] fifo_cnt;
  logic       key_ovf;
  logic       data_ovf;
  wire        tx_active = tx_busy | tx_hold;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] obs[$];
  int         obs_cyc[$];

  xor_key_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_byte   (key_byte),
    .key_clr    (key_clr),
    .data_valid (data_valid),
    .data_byte  (data_byte),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .key_len    (key_len),
    .fifo_cnt   (fifo_cnt),
    .key_ovf    (key_ovf),
    .data_ovf   (data_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every launched byte and the cycle it was launched in.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      obs.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
  end

  // Transmitter model: busy for 3 cycles after tx_start, then a 1-cycle tx_done.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_push(input logic [7:0] b);
    @(negedge clk);
    key_valid = 1'b1;
    key_byte  = b;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic key_clear();
    @(negedge clk);
    key_clr = 1'b1;
    @(negedge clk);
    key_clr = 1'b0;
  endtask

  task automatic data_push(input logic [7:0] b);
    @(negedge clk);
    data_valid = 1'b1;
    data_byte  = b;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (obs.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", tag, obs.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks += 6;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset tx_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
    if (key_len !== 5'd0) begin errors++; $display("FAIL reset key_len: got %0d want 0", key_len); end
    if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset fifo_cnt: got %0d want 0", fifo_cnt); end
    if (key_ovf !== 1'b0) begin errors++; $display("FAIL reset key_ovf: got %b want 0", key_ovf); end
    if (data_ovf !== 1'b0) begin errors++; $display("FAIL reset data_ovf: got %b want 0", data_ovf); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_passthrough();
    int c0;
    obs.delete();
    obs_cyc.delete();
    @(negedge clk);
    c0 = cyc;
    data_valid = 1'b1;
    data_byte  = 8'h41;
    @(negedge clk);
    data_byte  = 8'h42;
    @(negedge clk);
    data_valid = 1'b0;
    wait_tx(2, 200, "passthrough");
    idle(20);
    checks += 4;
    if (obs.size() !== 2) begin errors++; $display("FAIL pass count: got %0d want 2", obs.size()); end
    if (obs.size() > 0 && obs[0] !== 8'h41) begin errors++; $display("FAIL pass byte0: got %h want 41", obs[0]); end
    if (obs.size() > 1 && obs[1] !== 8'h42) begin errors++; $display("FAIL pass byte1: got %h want 42", obs[1]); end
    if (obs_cyc.size() > 0 && obs_cyc[0] !== c0 + 2) begin
      errors++;
      $display("FAIL pass latency: tx_start at cycle %0d want %0d", obs_cyc[0], c0 + 2);
    end
  endtask

  task automatic test_key_cycle();
    logic [7:0] exp [5];
    exp[0] = 8'h10; exp[1] = 8'h20; exp[2] = 8'h30; exp[3] = 8'h10; exp[4] = 8'h20;
    key_push(8'h10);
    key_push(8'h20);
    key_push(8'h30);
    checks++;
    if (key_len !== 5'd3) begin errors++; $display("FAIL keycyc key_len: got %0d want 3", key_len); end
    obs.delete();
    obs_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_byte  = 8'h00;
    end
    @(negedge clk);
    data_valid = 1'b0;
    wait_tx(5, 400, "keycyc");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs.size() <= i || obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL keycyc byte%0d: got %h want %h", i, (obs.size() > i) ? obs[i] : 8'hxx, exp[i]);
      end
    end
    idle(20);
  endtask

  task automatic test_fifo_overflow();
    key_clear();
    tx_hold = 1'b1;
    obs.delete();
    obs_cyc.delete();
    for (int i = 0; i < FD + 1; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_byte  = 8'(8'h60 + i);
    end
    @(negedge clk);
    data_valid = 1'b0;
    idle(2);
    checks += 3;
    if (fifo_cnt !== 4'(FD)) begin errors++; $display("FAIL ovf fifo_cnt: got %0d want %0d", fifo_cnt, FD); end
    if (data_ovf !== 1'b1) begin errors++; $display("FAIL ovf data_ovf: got %b want 1", data_ovf); end
    if (obs.size() !== 0) begin errors++; $display("FAIL ovf held launch: got %0d bytes want 0", obs.size()); end
    tx_hold = 1'b0;
    wait_tx(FD, 600, "ovf_drain");
    idle(40);
    checks++;
    if (obs.size() !== FD) begin errors++; $display("FAIL ovf sent count: got %0d want %0d", obs.size(), FD); end
    for (int i = 0; i < FD; i++) begin
      checks++;
      if (obs.size() <= i || obs[i] !== 8'(8'h60 + i)) begin
        errors++;
        $display("FAIL ovf byte%0d: got %h want %h", i, (obs.size() > i) ? obs[i] : 8'hxx, 8'(8'h60 + i));
      end
    end
  endtask

  task automatic test_key_overflow();
    key_clear();
    for (int i = 0; i < KD + 1; i++) key_push(8'(i + 1));
    checks += 2;
    if (key_len !== 5'(KD)) begin errors++; $display("FAIL kovf key_len: got %0d want %0d", key_len, KD); end
    if (key_ovf !== 1'b1) begin errors++; $display("FAIL kovf key_ovf: got %b want 1", key_ovf); end
    key_clear();
    checks += 2;
    if (key_len !== 5'd0) begin errors++; $display("FAIL kclr key_len: got %0d want 0", key_len); end
    if (key_ovf !== 1'b0) begin errors++; $display("FAIL kclr key_ovf: got %b want 0", key_ovf); end
  endtask

  task automatic test_same_cycle();
    // clear + key byte together
    key_push(8'h77);
    @(negedge clk);
    key_clr   = 1'b1;
    key_valid = 1'b1;
    key_byte  = 8'hAA;
    @(negedge clk);
    key_clr   = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (key_len !== 5'd1) begin errors++; $display("FAIL clr+key key_len: got %0d want 1", key_len); end
    obs.delete();
    data_push(8'h0F);
    data_push(8'h0F);
    wait_tx(2, 200, "clr+key");
    checks += 2;
    if (obs.size() > 0 && obs[0] !== 8'hA5) begin errors++; $display("FAIL clr+key data0: got %h want a5", obs[0]); end
    if (obs.size() > 1 && obs[1] !== 8'hA5) begin errors++; $display("FAIL clr+key data1: got %h want a5", obs[1]); end
    idle(10);

    // data + first key byte together: data passes through, next byte uses the key
    key_clear();
    obs.delete();
    @(negedge clk);
    data_valid = 1'b1;
    data_byte  = 8'h33;
    key_valid  = 1'b1;
    key_byte   = 8'h55;
    @(negedge clk);
    data_valid = 1'b0;
    key_valid  = 1'b0;
    data_push(8'h33);
    wait_tx(2, 200, "data+key");
    checks += 3;
    if (key_len !== 5'd1) begin errors++; $display("FAIL data+key key_len: got %0d want 1", key_len); end
    if (obs.size() > 0 && obs[0] !== 8'h33) begin errors++; $display("FAIL data+key pass: got %h want 33", obs[0]); end
    if (obs.size() > 1 && obs[1] !== 8'h66) begin errors++; $display("FAIL data+key enc: got %h want 66", obs[1]); end
    idle(10);

    // data + clear together: encrypted with old key, key discarded afterwards
    key_clear();
    key_push(8'h01);
    key_push(8'h02);
    obs.delete();
    @(negedge clk);
    data_valid = 1'b1;
    data_byte  = 8'h00;
    key_clr    = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    key_clr    = 1'b0;
    data_push(8'h00);
    wait_tx(2, 200, "data+clr");
    checks += 4;
    if (key_len !== 5'd0) begin errors++; $display("FAIL data+clr key_len: got %0d want 0", key_len); end
    if (obs.size() > 0 && obs[0] !== 8'h01) begin errors++; $display("FAIL data+clr old key: got %h want 01", obs[0]); end
    if (obs.size() > 1 && obs[1] !== 8'h00) begin errors++; $display("FAIL data+clr pass: got %h want 00", obs[1]); end
    if (data_ovf !== 1'b1) begin errors++; $display("FAIL sticky data_ovf: got %b want 1", data_ovf); end
    idle(20);
  endtask

  task automatic test_reset_mid_op();
    obs.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_byte  = 8'(8'hC0 + i);
    end
    @(negedge clk);
    data_valid = 1'b0;
    checks += 2;
    if (fifo_cnt !== 4'd2) begin errors++; $display("FAIL midrst queued: got %0d want 2", fifo_cnt); end
    if (obs.size() !== 1) begin errors++; $display("FAIL midrst launched: got %0d want 1", obs.size()); end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst tx_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst tx_data: got %h want 00", tx_data); end
    if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL midrst fifo_cnt: got %0d want 0", fifo_cnt); end
    if (data_ovf !== 1'b0) begin errors++; $display("FAIL midrst data_ovf: got %b want 0", data_ovf); end
    if (key_len !== 5'd0) begin errors++; $display("FAIL midrst key_len: got %0d want 0", key_len); end
    idle(3);
    obs.delete();
    rst_n = 1'b1;
    idle(40);
    checks += 2;
    if (obs.size() !== 0) begin errors++; $display("FAIL midrst relaunch: got %0d tx_start want 0", obs.size()); end
    if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL midrst post fifo_cnt: got %0d want 0", fifo_cnt); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_key_cycle();
    test_fifo_overflow();
    test_key_overflow();
    test_same_cycle();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
